// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - 3-source round-robin writeback arbiter, optional bypass via WB_ARBITER_BYPASS_EN
module wb_arbiter #(
  parameter int N     = 5,
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic [2:0]         req_valid,
  input  logic [3*N-1:0]     req_reg,
  input  logic [3*WIDTH-1:0] req_data,
  output logic [2:0]         req_ready,
  output logic               rf_wenable,
  output logic [N-1:0]       rf_reg_in,
  output logic [WIDTH-1:0]   rf_din,
  output logic [15:0]        wb_count
`ifdef WB_ARBITER_BYPASS_EN
  ,
  input  logic [N-1:0]       rd_a,
  input  logic [N-1:0]       rd_b,
  output logic               byp_hit_a,
  output logic               byp_hit_b,
  output logic [WIDTH-1:0]   byp_data_a,
  output logic [WIDTH-1:0]   byp_data_b
`endif
);

  // last granted source; the search starts one past it
  logic [1:0]       ptr;
  logic [2:0]       zero_req;
  logic [2:0]       cand;
  logic [2:0]       gnt;
  logic             gnt_any;
  logic [1:0]       gnt_idx;
  logic [N-1:0]     gnt_reg;
  logic [WIDTH-1:0] gnt_data;

  // split requests into r0 writes (always accepted, dropped) and real candidates
  always_comb begin
    zero_req = 3'b000;
    cand     = 3'b000;
    for (int i = 0; i < 3; i++) begin
      zero_req[i] = req_valid[i] && (req_reg[i*N +: N] == '0);
      cand[i]     = req_valid[i] && (req_reg[i*N +: N] != '0);
    end
  end

  // round-robin pick starting at (ptr+1) mod 3; ptr==3 never occurs and falls to source 0 first
  always_comb begin
    gnt = 3'b000;
    if (!hold) begin
      case (ptr)
        2'd0: begin
          if (cand[1])      gnt = 3'b010;
          else if (cand[2]) gnt = 3'b100;
          else if (cand[0]) gnt = 3'b001;
        end
        2'd1: begin
          if (cand[2])      gnt = 3'b100;
          else if (cand[0]) gnt = 3'b001;
          else if (cand[1]) gnt = 3'b010;
        end
        default: begin
          if (cand[0])      gnt = 3'b001;
          else if (cand[1]) gnt = 3'b010;
          else if (cand[2]) gnt = 3'b100;
        end
      endcase
    end
  end

  // encode the winner and select its index and data
  always_comb begin
    gnt_any  = |gnt;
    gnt_idx  = 2'd0;
    gnt_reg  = req_reg[0 +: N];
    gnt_data = req_data[0 +: WIDTH];
    if (gnt[1]) begin
      gnt_idx  = 2'd1;
      gnt_reg  = req_reg[N +: N];
      gnt_data = req_data[WIDTH +: WIDTH];
    end else if (gnt[2]) begin
      gnt_idx  = 2'd2;
      gnt_reg  = req_reg[2*N +: N];
      gnt_data = req_data[2*WIDTH +: WIDTH];
    end
  end

  // nothing is accepted while reset is held
  always_comb begin
    req_ready = rst ? (zero_req | gnt) : 3'b000;
  end

  // register the granted write, advance the pointer and count issued writes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr        <= 2'd2;
      rf_wenable <= 1'b0;
      rf_reg_in  <= '0;
      rf_din     <= '0;
      wb_count   <= 16'd0;
    end else begin
      rf_wenable <= gnt_any;
      if (gnt_any) begin
        ptr       <= gnt_idx;
        rf_reg_in <= gnt_reg;
        rf_din    <= gnt_data;
      end
      if (rf_wenable) begin
        wb_count <= wb_count + 16'd1;
      end
    end
  end

`ifdef WB_ARBITER_BYPASS_EN
  // forward the in-flight write to the two read ports; r0 never hits
  always_comb begin
    byp_hit_a  = rf_wenable && (rf_reg_in == rd_a) && (rd_a != '0);
    byp_hit_b  = rf_wenable && (rf_reg_in == rd_b) && (rd_b != '0);
    byp_data_a = rf_din;
    byp_data_b = rf_din;
  end
`endif

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter N, default 5, register index width (2^N architectural registers).
REQ-002 Parameter WIDTH, default 32, register data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (asserted at 0).
REQ-005 hold  input  1  freeze: no new grants while 1.
REQ-006 req_valid  input  3  writeback request per source (0=ALU, 1=MEM, 2=MUL).
REQ-007 req_reg  input  3xN  destination index per source.
REQ-008 req_data  input  3xWIDTH  write data per source.
REQ-009 req_ready  output  3  per-source accept; a transfer occurs when valid and ready are both 1 in a cycle.
REQ-010 rf_wenable  output  1  register file write enable, registered.
REQ-011 rf_reg_in  output  N  register file write index, registered.
REQ-012 rf_din  output  WIDTH  register file write data, registered.
REQ-013 wb_count  output  16  number of issued register file writes.

Function
REQ-014 req_ready SHALL be combinational from req_valid, req_reg, hold and the priority pointer.
REQ-015 A valid request with req_reg==0 SHALL get req_ready=1 in the same cycle, regardless of hold or other requests, and SHALL NOT produce a write.
REQ-016 While hold=0, among valid requests with req_reg!=0, exactly one SHALL be granted (req_ready=1), chosen round-robin.
REQ-017 Round-robin search SHALL start at (ptr+1) mod 3; ptr is a 2-bit register holding the last granted source.
REQ-018 ptr SHALL update to the granted source on a grant and SHALL hold when there is no grant.
REQ-019 While hold=1, req_ready SHALL be 0 for all nonzero-index requests and rf_wenable SHALL be 0 in the following cycle.
REQ-020 A grant in cycle t SHALL drive rf_wenable=1, rf_reg_in=req_reg, rf_din=req_data in cycle t+1 (one-cycle latency); with no grant, rf_wenable=0 and rf_reg_in/rf_din hold their values.
REQ-021 Ungranted requests SHALL keep req_ready=0; sources hold valid, reg and data stable until accepted.
REQ-022 Any continuously valid source SHALL be granted within 3 consecutive cycles with hold=0.
REQ-023 wb_count SHALL increment by 1 on every cycle in which rf_wenable=1, and SHALL wrap from 0xFFFF to 0x0000.
REQ-024 rf_wenable SHALL never be 1 while rf_reg_in==0.

Reset
REQ-025 While rst=0: rf_wenable=0, rf_reg_in=0, rf_din=0, wb_count=0, ptr=2 (so source 0 has first priority), independent of clk.
REQ-026 A grant made in the cycle in which rst asserts SHALL be discarded; no write SHALL issue after rst deasserts unless a new grant occurs.
REQ-027 req_ready SHALL be 0 for all sources while rst=0.

Configuration
REQ-028 Macro WB_ARBITER_BYPASS_EN: when defined, the module SHALL add inputs rd_a, rd_b (N each) and outputs byp_hit_a, byp_hit_b (1 each), byp_data_a, byp_data_b (WIDTH each).
REQ-029 With the macro, byp_hit_x SHALL be rf_wenable && rf_reg_in==rd_x && rd_x!=0, and byp_data_x SHALL be rf_din, both combinational.
REQ-030 Without the macro these ports SHALL NOT exist and behaviour of REQ-001..027 SHALL be unchanged.

Verification
REQ-031 Reset then req_valid=3'b111, reg=5/6/7, hold=0 -> grants 0,1,2 in cycles 1,2,3; writes r5,r6,r7 in cycles 2,3,4; wb_count=3.
REQ-032 Only source 1 valid with reg=0, data=0xDEADBEEF -> req_ready[1]=1 same cycle, rf_wenable stays 0, wb_count unchanged.
REQ-033 hold=1 for 4 cycles with sources 0 and 2 valid (reg 3, 4) -> no ready, no write; hold=0 -> source 0 granted first, then source 2.
REQ-034 Preload wb_count to 0xFFFE by 0xFFFE writes, issue 2 more -> wb_count reads 0xFFFF then 0x0000.
REQ-035 Grant source 2 (reg 9), assert rst in the next cycle -> rf_wenable=0 immediately; after release no write to r9 appears.
REQ-036 With WB_ARBITER_BYPASS_EN: write r12=0x1234, rd_a=12, rd_b=0 -> in write cycle byp_hit_a=1, byp_data_a=0x1234, byp_hit_b=0.
